branch_predictor_btb: RTL

- Parametrised dynamic branch predictor: direct-mapped table of 2-bit saturating counters plus a branch target buffer (BTB).
- Successor to the static PC-control next-PC logic.
- Sits in the IF stage of the pipelined CPU and supplies the predicted next fetch PC each cycle. The ID stage resolves branches and trains the table through the update port.
- Also flags mispredictions and counts them for performance checking.

---
 rtl/branch_predictor_btb.sv | 111 +++++++++++
 1 files changed

// File: rtl/branch_predictor_btb.sv
// Dynamic branch predictor: direct-mapped 2-bit saturating counters plus branch target buffer.
// Lookup is combinational from the IF PC; training comes from the resolved branch in ID.
module branch_predictor_btb #(
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned INDEX_BITS = 4,
  parameter logic [1:0]  INIT_CNT   = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                flush,
  input  logic [PC_WIDTH-1:0] IF_PC_curr,
  output logic                IF_hit,
  output logic                IF_predicted_taken,
  output logic [PC_WIDTH-1:0] IF_predicted_target,
  input  logic                ID_update,
  input  logic [PC_WIDTH-1:0] ID_PC_curr,
  input  logic                ID_actual_taken,
  input  logic [PC_WIDTH-1:0] ID_actual_target,
  input  logic                ID_predicted_taken,
  input  logic [PC_WIDTH-1:0] ID_predicted_target,
  output logic                mispredicted,
  output logic [15:0]         mispredict_count
);

  localparam int Entries = 2 ** INDEX_BITS;
  localparam int TagW    = PC_WIDTH - INDEX_BITS - 1;

  logic                valid_q  [Entries];
  logic [TagW-1:0]     tag_q    [Entries];
  logic [1:0]          cnt_q    [Entries];
  logic [PC_WIDTH-1:0] target_q [Entries];
  logic [15:0]         count_q, count_d;

  logic [INDEX_BITS-1:0] if_idx, id_idx;
  logic [TagW-1:0]       if_tag, id_tag;
  logic                  id_hit;
  logic                  write_en;
  logic [1:0]            cnt_upd;
  logic [PC_WIDTH-1:0]   target_upd;
  logic                  unused_pc_lsb;

  // PCs are halfword aligned, so bit 0 takes no part in indexing or tagging.
  assign if_idx        = IF_PC_curr[INDEX_BITS:1];
  assign if_tag        = IF_PC_curr[PC_WIDTH-1:INDEX_BITS+1];
  assign id_idx        = ID_PC_curr[INDEX_BITS:1];
  assign id_tag        = ID_PC_curr[PC_WIDTH-1:INDEX_BITS+1];
  assign unused_pc_lsb = ID_PC_curr[0];

  always_comb begin
    IF_hit              = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    IF_predicted_taken  = IF_hit && cnt_q[if_idx][1];
    IF_predicted_target = IF_predicted_taken ? target_q[if_idx]
                                             : IF_PC_curr + PC_WIDTH'(2);
  end

  assign mispredicted = ID_update &&
                        ((ID_actual_taken != ID_predicted_taken) ||
                         (ID_actual_taken && (ID_actual_target != ID_predicted_target)));

  always_comb begin
    id_hit     = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    write_en   = enable && ID_update && !flush;
    cnt_upd    = ID_actual_taken ? 2'b10 : 2'b01;
    target_upd = ID_actual_taken ? ID_actual_target : '0;
    if (id_hit) begin
      if (ID_actual_taken) begin
        cnt_upd = (cnt_q[id_idx] == 2'b11) ? 2'b11 : cnt_q[id_idx] + 2'd1;
      end else begin
        cnt_upd    = (cnt_q[id_idx] == 2'b00) ? 2'b00 : cnt_q[id_idx] - 2'd1;
        target_upd = target_q[id_idx];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (enable && mispredicted && (count_q != 16'hFFFF)) begin
      count_d = count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        cnt_q[i]    <= INIT_CNT;
        target_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      count_q <= count_d;
      // Flush invalidates regardless of stall and wins over a same-cycle update.
      if (flush) begin
        for (int i = 0; i < Entries; i++) begin
          valid_q[i] <= 1'b0;
          cnt_q[i]   <= INIT_CNT;
        end
      end else if (write_en) begin
        valid_q[id_idx]  <= 1'b1;
        tag_q[id_idx]    <= id_tag;
        cnt_q[id_idx]    <= cnt_upd;
        target_q[id_idx] <= target_upd;
      end
    end
  end

  assign mispredict_count = count_q;

endmodule
